regfile_scoreboard: RTL and testbench

Parametrised register file for the pipelined CPU. It has two write ports: port A is the ALU writeback and port B is the load/memory writeback. Two combinational read ports support optional same-cycle write bypass. An integrated busy scoreboard tracks registers that have outstanding loads, so decode can stall on RAW hazards without a separate hazard table.

---
 rtl/regfile_scoreboard.sv | 114 +++++++++++
 tb/tb_regfile_scoreboard.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with ALU (A) and load (B) write ports, bypassed read ports and
// a per-register busy scoreboard for outstanding loads.
module regfile_scoreboard #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned ZERO_REG     = 1,
    parameter int unsigned BYPASS       = 1,
    parameter int unsigned PRESET_INDEX = 1,
    parameter logic [DATA_WIDTH-1:0] PRESET_VALUE = DATA_WIDTH'(1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rd_index1,
    input  logic [ADDR_WIDTH-1:0] rd_index2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    output logic                  rd_busy1,
    output logic                  rd_busy2,
    input  logic                  wa_enable,
    input  logic [ADDR_WIDTH-1:0] wa_index,
    input  logic [DATA_WIDTH-1:0] wa_data,
    input  logic                  wb_enable,
    input  logic [ADDR_WIDTH-1:0] wb_index,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  claim_enable,
    input  logic [ADDR_WIDTH-1:0] claim_index,
    input  logic                  flush,
    output logic [ADDR_WIDTH:0]   pending_count
);

    localparam int unsigned REG_COUNT = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam bit          PRESET_ON = !((ZERO_REG != 0) && (PRESET_INDEX == 0));

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [REG_COUNT-1:0]  busy;
    logic [REG_COUNT-1:0]  busy_next;
    logic [CNT_WIDTH-1:0]  busy_total;

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    // Bypass order: load writeback beats ALU writeback beats stored value.
    function automatic logic [DATA_WIDTH-1:0] read_value(input logic [ADDR_WIDTH-1:0] idx,
                                                          input logic [DATA_WIDTH-1:0] stored);
        if (is_zero(idx))
            return '0;
        if ((BYPASS != 0) && wb_enable && (wb_index == idx))
            return wb_data;
        if ((BYPASS != 0) && wa_enable && (wa_index == idx))
            return wa_data;
        return stored;
    endfunction

    // A load completing this cycle hides the busy bit when bypassing.
    function automatic logic read_busy(input logic [ADDR_WIDTH-1:0] idx, input logic raw);
        if (is_zero(idx))
            return 1'b0;
        if ((BYPASS != 0) && wb_enable && (wb_index == idx))
            return 1'b0;
        return raw;
    endfunction

    always_comb begin
        rd_data1 = read_value(rd_index1, regs[rd_index1]);
        rd_data2 = read_value(rd_index2, regs[rd_index2]);
        rd_busy1 = read_busy(rd_index1, busy[rd_index1]);
        rd_busy2 = read_busy(rd_index2, busy[rd_index2]);
    end

    // Per-register busy update: flush, then claim, then release.
    always_comb begin
        busy_next = busy;
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            if (flush)
                busy_next[ADDR_WIDTH'(i)] = 1'b0;
            else if (claim_enable && (claim_index == ADDR_WIDTH'(i)) && !is_zero(ADDR_WIDTH'(i)))
                busy_next[ADDR_WIDTH'(i)] = 1'b1;
            else if (wb_enable && (wb_index == ADDR_WIDTH'(i)))
                busy_next[ADDR_WIDTH'(i)] = 1'b0;
        end
    end

    always_comb begin
        busy_total = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++)
            busy_total = busy_total + CNT_WIDTH'(busy_next[ADDR_WIDTH'(i)]);
    end

    // Data array; port B is written last so it wins an index collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < REG_COUNT; i++)
                regs[ADDR_WIDTH'(i)] <= (PRESET_ON && (i == PRESET_INDEX)) ? PRESET_VALUE : '0;
        end else begin
            if (wa_enable && !is_zero(wa_index))
                regs[wa_index] <= wa_data;
            if (wb_enable && !is_zero(wb_index))
                regs[wb_index] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy          <= '0;
            pending_count <= '0;
        end else begin
            busy          <= busy_next;
            pending_count <= busy_total;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised and directed bench for regfile_scoreboard against an array-based model;
// a second instance with BYPASS=0 checks the non-bypassed read behaviour.
module tb_regfile_scoreboard;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned RC = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] rd_index1 = '0, rd_index2 = '0;
    logic [DW-1:0] rd_data1, rd_data2, nb_data1, nb_data2;
    logic          rd_busy1, rd_busy2, nb_busy1, nb_busy2;
    logic          wa_enable = 1'b0, wb_enable = 1'b0, claim_enable = 1'b0, flush = 1'b0;
    logic [AW-1:0] wa_index = '0, wb_index = '0, claim_index = '0;
    logic [DW-1:0] wa_data = '0, wb_data = '0;
    logic [AW:0]   pending_count, nb_pending;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model state
    logic [DW-1:0] m_regs [RC];
    bit            m_busy [RC];
    int            m_pend;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk(clk), .reset(reset),
        .rd_index1(rd_index1), .rd_index2(rd_index2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wa_enable(wa_enable), .wa_index(wa_index), .wa_data(wa_data),
        .wb_enable(wb_enable), .wb_index(wb_index), .wb_data(wb_data),
        .claim_enable(claim_enable), .claim_index(claim_index),
        .flush(flush), .pending_count(pending_count)
    );

    regfile_scoreboard #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset),
        .rd_index1(rd_index1), .rd_index2(rd_index2),
        .rd_data1(nb_data1), .rd_data2(nb_data2),
        .rd_busy1(nb_busy1), .rd_busy2(nb_busy2),
        .wa_enable(wa_enable), .wa_index(wa_index), .wa_data(wa_data),
        .wb_enable(wb_enable), .wb_index(wb_index), .wb_data(wb_data),
        .claim_enable(claim_enable), .claim_index(claim_index),
        .flush(flush), .pending_count(nb_pending)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] idx, input bit bypass);
        if (idx == 0) return '0;
        if (bypass && wb_enable && wb_index == idx) return wb_data;
        if (bypass && wa_enable && wa_index == idx) return wa_data;
        return m_regs[idx];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] idx, input bit bypass);
        if (bypass && wb_enable && wb_index == idx) return 1'b0;
        return m_busy[idx];
    endfunction

    // Model commit of one clock edge, from the rules: reset, writes, busy set/clear, count.
    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < RC; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_regs[1] = 32'd1;
        end else begin
            if (wa_enable && wa_index != 0) m_regs[wa_index] = wa_data;
            if (wb_enable && wb_index != 0) m_regs[wb_index] = wb_data;
            if (flush) begin
                for (int i = 0; i < RC; i++) m_busy[i] = 1'b0;
            end else begin
                if (wb_enable) m_busy[wb_index] = 1'b0;
                if (claim_enable && claim_index != 0) m_busy[claim_index] = 1'b1;
            end
        end
        m_pend = 0;
        for (int i = 0; i < RC; i++) m_pend += int'(m_busy[i]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wa_enable = 1'b0; wb_enable = 1'b0; claim_enable = 1'b0; flush = 1'b0; reset = 1'b0;
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check("rd_data1", rd_data1, exp_data(rd_index1, 1'b1));
            check("rd_data2", rd_data2, exp_data(rd_index2, 1'b1));
            check("rd_busy1", 32'(rd_busy1), 32'(exp_busy(rd_index1, 1'b1)));
            check("rd_busy2", 32'(rd_busy2), 32'(exp_busy(rd_index2, 1'b1)));
            check("pending_count", 32'(pending_count), 32'(m_pend));
            check("nb_rd_data1", nb_data1, exp_data(rd_index1, 1'b0));
            check("nb_rd_busy2", 32'(nb_busy2), 32'(exp_busy(rd_index2, 1'b0)));
            check("nb_pending", 32'(nb_pending), 32'(m_pend));
        end
    end

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_en = 1'b1;

        // Reset state
        rd_index1 = 5'd1; rd_index2 = 5'd2; #1;
        check("lit_reset_r1", rd_data1, 32'd1);
        check("lit_reset_r2", rd_data2, 32'd0);
        check("lit_reset_busy", 32'({rd_busy1, rd_busy2}), 32'd0);
        check("lit_reset_pend", 32'(pending_count), 32'd0);
        rd_index1 = 5'd0; #1;
        check("lit_reset_r0", rd_data1, 32'd0);

        // Same-index A/B collision
        wa_enable = 1'b1; wa_index = 5'd5; wa_data = 32'hDEADBEEF;
        wb_enable = 1'b1; wb_index = 5'd5; wb_data = 32'h12345678;
        rd_index1 = 5'd5; #1;
        check("lit_collide_bypass", rd_data1, 32'h12345678);
        check("lit_collide_nobypass", nb_data1, 32'h0);
        step(); idle(); #1;
        check("lit_collide_stored", rd_data1, 32'h12345678);
        check("lit_collide_stored_nb", nb_data1, 32'h12345678);

        // Claim and release r7
        claim_enable = 1'b1; claim_index = 5'd7;
        step(); idle(); rd_index1 = 5'd7; #1;
        check("lit_claim_busy", 32'(rd_busy1), 32'd1);
        check("lit_claim_pend", 32'(pending_count), 32'd1);
        wb_enable = 1'b1; wb_index = 5'd7; wb_data = 32'hA5; #1;
        check("lit_release_busy", 32'(rd_busy1), 32'd0);
        check("lit_release_data", rd_data1, 32'hA5);
        check("lit_release_busy_nb", 32'(nb_busy1), 32'd1);
        step(); idle(); #1;
        check("lit_release_pend", 32'(pending_count), 32'd0);

        // Claim and writeback r3 in the same cycle: claim wins
        claim_enable = 1'b1; claim_index = 5'd3;
        wb_enable = 1'b1; wb_index = 5'd3; wb_data = 32'h33;
        step(); idle(); rd_index1 = 5'd3; #1;
        check("lit_claimwb_busy", 32'(rd_busy1), 32'd1);
        check("lit_claimwb_data", rd_data1, 32'h33);
        check("lit_claimwb_pend", 32'(pending_count), 32'd1);
        claim_enable = 1'b1; claim_index = 5'd3;
        step(); idle(); #1;
        check("lit_reclaim_pend", 32'(pending_count), 32'd1);

        // Claims of r2, r4, r6 on top of r3, then flush with a claim of r8
        claim_enable = 1'b1; claim_index = 5'd2; step();
        claim_index = 5'd4; step();
        claim_index = 5'd6; step();
        idle(); #1;
        check("lit_multi_pend", 32'(pending_count), 32'd4);
        flush = 1'b1; claim_enable = 1'b1; claim_index = 5'd8;
        step(); idle(); rd_index1 = 5'd2; rd_index2 = 5'd8; #1;
        check("lit_flush_busy", 32'({rd_busy1, rd_busy2}), 32'd0);
        check("lit_flush_pend", 32'(pending_count), 32'd0);

        // Zero register ignores writes and claims
        wa_enable = 1'b1; wa_index = 5'd0; wa_data = 32'h11;
        wb_enable = 1'b1; wb_index = 5'd0; wb_data = 32'h22;
        claim_enable = 1'b1; claim_index = 5'd0;
        rd_index1 = 5'd0; #1;
        check("lit_r0_bypass", rd_data1, 32'd0);
        step(); idle(); #1;
        check("lit_r0_data", rd_data1, 32'd0);
        check("lit_r0_busy", 32'(rd_busy1), 32'd0);
        check("lit_r0_pend", 32'(pending_count), 32'd0);

        // Reset while r9 is busy and holds 0x55
        claim_enable = 1'b1; claim_index = 5'd9;
        wa_enable = 1'b1; wa_index = 5'd9; wa_data = 32'h55;
        step(); idle(); rd_index1 = 5'd9; rd_index2 = 5'd1; #1;
        check("lit_r9_data", rd_data1, 32'h55);
        check("lit_r9_busy", 32'(rd_busy1), 32'd1);
        reset = 1'b1; claim_enable = 1'b1; claim_index = 5'd10;
        step(); idle(); #1;
        check("lit_rst_r9_data", rd_data1, 32'd0);
        check("lit_rst_r9_busy", 32'(rd_busy1), 32'd0);
        check("lit_rst_pend", 32'(pending_count), 32'd0);
        check("lit_rst_r1", rd_data2, 32'd1);

        // Random traffic; small index range half the time to force collisions
        for (int n = 0; n < 3000; n++) begin
            int unsigned hi;
            hi = ($urandom_range(0, 1) == 0) ? 7 : 31;
            reset        = ($urandom_range(0, 299) == 0);
            flush        = ($urandom_range(0, 23) == 0);
            wa_enable    = $urandom_range(0, 1);
            wb_enable    = ($urandom_range(0, 2) == 0);
            claim_enable = ($urandom_range(0, 1) == 0);
            wa_index     = AW'($urandom_range(0, hi));
            wb_index     = AW'($urandom_range(0, hi));
            claim_index  = AW'($urandom_range(0, hi));
            rd_index1    = AW'($urandom_range(0, hi));
            rd_index2    = AW'($urandom_range(0, hi));
            wa_data      = $urandom;
            wb_data      = $urandom;
            step();
        end
        idle();
        step();
        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
